// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute/
// memory/write-back, drives datapath selects and strobes, and counts retired instructions.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             branch_eq,
    output logic             branch_ne,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic             pc_write_raw, ir_write_raw, mem_read_raw, mem_write_raw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        branch_eq     = 1'b0;
        branch_ne     = 1'b0;
        iord          = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        instr_done    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                alu_src_b    = 2'b01;
                pc_write_raw = mem_ready;
                ir_write_raw = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            // Branch target is precomputed here while the opcode is decoded
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_RTYPE:       state_d = S_EXECUTE;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    OP_ADDI:        state_d = S_ADDI_EXEC;
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read_raw = 1'b1;
                iord         = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write_raw = 1'b1;
                iord          = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_source  = 2'b01;
                branch_eq  = (opcode == OP_BEQ);
                branch_ne  = (opcode == OP_BNE);
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_write_raw = 1'b1;
                pc_source    = 2'b10;
                instr_done   = 1'b1;
                state_d      = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        instr_count_d = instr_done ? instr_count_q + CNT_W'(1) : instr_count_q;
    end

    // Memory and PC strobes must not fire while reset is held, even though FETCH is decoded
    assign pc_write    = pc_write_raw  & ~reset;
    assign ir_write    = ir_write_raw  & ~reset;
    assign mem_read    = mem_read_raw  & ~reset;
    assign mem_write   = mem_write_raw & ~reset;
    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: per-cycle state/strobe/select
// tables for each instruction class, stalls, mid-instruction reset and counter wrap.
module tb_multicycle_control;

    localparam int CNT_W = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    // strb = {pc_write, ir_write, mem_read, mem_write, reg_write, iord, mem_to_reg, reg_dst}
    localparam logic [7:0] SB_F1   = 8'b1110_0000;
    localparam logic [7:0] SB_F0   = 8'b0010_0000;
    localparam logic [7:0] SB_NONE = 8'b0000_0000;
    localparam logic [7:0] SB_MR   = 8'b0010_0100;
    localparam logic [7:0] SB_MWB  = 8'b0000_1010;
    localparam logic [7:0] SB_MW   = 8'b0001_0100;
    localparam logic [7:0] SB_AWB  = 8'b0000_1001;
    localparam logic [7:0] SB_IWB  = 8'b0000_1000;
    localparam logic [7:0] SB_JMP  = 8'b1000_0000;
    // sel = {alu_src_a, alu_src_b, alu_op, pc_source}
    localparam logic [6:0] SL_F    = 7'b0010000;
    localparam logic [6:0] SL_DEC  = 7'b0110000;
    localparam logic [6:0] SL_MA   = 7'b1100000;
    localparam logic [6:0] SL_EX   = 7'b1001000;
    localparam logic [6:0] SL_BR   = 7'b1000101;
    localparam logic [6:0] SL_J    = 7'b0000010;
    localparam logic [6:0] SL_AE   = 7'b1101100;
    localparam logic [6:0] SL_0    = 7'b0000000;
    // misc = {branch_eq, branch_ne, illegal_op, instr_done}
    localparam logic [3:0] MS_0    = 4'b0000;
    localparam logic [3:0] MS_DONE = 4'b0001;
    localparam logic [3:0] MS_BEQ  = 4'b1001;
    localparam logic [3:0] MS_BNE  = 4'b0101;
    localparam logic [3:0] MS_ILL  = 4'b0011;

    logic             clk;
    logic             reset;
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_write, branch_eq, branch_ne, iord, mem_read, mem_write, ir_write;
    logic             mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, instr_done;
    logic [1:0]       alu_src_b, alu_op, pc_source;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    logic [7:0] strb;
    logic [6:0] sel;
    logic [3:0] misc;
    int errors = 0;
    int checks = 0;

    assign strb = {pc_write, ir_write, mem_read, mem_write, reg_write, iord, mem_to_reg, reg_dst};
    assign sel  = {alu_src_a, alu_src_b, alu_op, pc_source};
    assign misc = {branch_eq, branch_ne, illegal_op, instr_done};

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .branch_eq(branch_eq), .branch_ne(branch_ne), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .illegal_op(illegal_op),
        .instr_done(instr_done), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; opcode = OP_R;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (state !== 4'd0) begin errors++; $display("[TB] FAIL reset_state got=%0d exp=0", state); end
        checks++; if (instr_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count got=%0d exp=0", instr_count); end
        checks++; if (strb !== SB_NONE) begin errors++; $display("[TB] FAIL reset_strb got=%b exp=%b", strb, SB_NONE); end
        checks++; if (sel !== SL_F) begin errors++; $display("[TB] FAIL reset_sel got=%b exp=%b", sel, SL_F); end
        checks++; if (misc !== MS_0) begin errors++; $display("[TB] FAIL reset_misc got=%b exp=%b", misc, MS_0); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_rtype();
        logic [3:0] st [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
        logic [7:0] sb [4] = '{SB_F1, SB_NONE, SB_NONE, SB_AWB};
        logic [6:0] sl [4] = '{SL_F, SL_DEC, SL_EX, SL_0};
        logic [3:0] ms [4] = '{MS_0, MS_0, MS_0, MS_DONE};
        opcode = OP_R; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (state !== st[i]) begin errors++; $display("[TB] FAIL rtype_state[%0d] got=%0d exp=%0d", i, state, st[i]); end
            checks++; if (strb !== sb[i]) begin errors++; $display("[TB] FAIL rtype_strb[%0d] got=%b exp=%b", i, strb, sb[i]); end
            checks++; if (sel !== sl[i]) begin errors++; $display("[TB] FAIL rtype_sel[%0d] got=%b exp=%b", i, sel, sl[i]); end
            checks++; if (misc !== ms[i]) begin errors++; $display("[TB] FAIL rtype_misc[%0d] got=%b exp=%b", i, misc, ms[i]); end
            @(posedge clk); #1;
        end
        checks++; if (instr_count !== 4'd1) begin errors++; $display("[TB] FAIL rtype_count got=%0d exp=1", instr_count); end
    endtask

    task automatic test_lw_stall();
        logic       rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] st  [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
        logic [7:0] sb  [8] = '{SB_F1, SB_NONE, SB_NONE, SB_MR, SB_MR, SB_MR, SB_MR, SB_MWB};
        logic [6:0] sl  [8] = '{SL_F, SL_DEC, SL_MA, SL_0, SL_0, SL_0, SL_0, SL_0};
        logic [3:0] ms  [8] = '{MS_0, MS_0, MS_0, MS_0, MS_0, MS_0, MS_0, MS_DONE};
        opcode = OP_LW;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            checks++; if (state !== st[i]) begin errors++; $display("[TB] FAIL lw_state[%0d] got=%0d exp=%0d", i, state, st[i]); end
            checks++; if (strb !== sb[i]) begin errors++; $display("[TB] FAIL lw_strb[%0d] got=%b exp=%b", i, strb, sb[i]); end
            checks++; if (sel !== sl[i]) begin errors++; $display("[TB] FAIL lw_sel[%0d] got=%b exp=%b", i, sel, sl[i]); end
            checks++; if (misc !== ms[i]) begin errors++; $display("[TB] FAIL lw_misc[%0d] got=%b exp=%b", i, misc, ms[i]); end
            @(posedge clk); #1;
        end
        checks++; if (state !== 4'd0) begin errors++; $display("[TB] FAIL lw_end_state got=%0d exp=0", state); end
        checks++; if (instr_count !== 4'd2) begin errors++; $display("[TB] FAIL lw_count got=%0d exp=2", instr_count); end
    endtask

    task automatic test_branches();
        logic [5:0] op [6] = '{OP_BEQ, OP_BEQ, OP_BEQ, OP_BNE, OP_BNE, OP_BNE};
        logic [3:0] st [6] = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd8};
        logic [7:0] sb [6] = '{SB_F1, SB_NONE, SB_NONE, SB_F1, SB_NONE, SB_NONE};
        logic [6:0] sl [6] = '{SL_F, SL_DEC, SL_BR, SL_F, SL_DEC, SL_BR};
        logic [3:0] ms [6] = '{MS_0, MS_0, MS_BEQ, MS_0, MS_0, MS_BNE};
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            opcode = op[i];
            @(negedge clk);
            checks++; if (state !== st[i]) begin errors++; $display("[TB] FAIL br_state[%0d] got=%0d exp=%0d", i, state, st[i]); end
            checks++; if (strb !== sb[i]) begin errors++; $display("[TB] FAIL br_strb[%0d] got=%b exp=%b", i, strb, sb[i]); end
            checks++; if (sel !== sl[i]) begin errors++; $display("[TB] FAIL br_sel[%0d] got=%b exp=%b", i, sel, sl[i]); end
            checks++; if (misc !== ms[i]) begin errors++; $display("[TB] FAIL br_misc[%0d] got=%b exp=%b", i, misc, ms[i]); end
            @(posedge clk); #1;
        end
        checks++; if (instr_count !== 4'd4) begin errors++; $display("[TB] FAIL br_count got=%0d exp=4", instr_count); end
    endtask

    task automatic test_addi_sw();
        logic [5:0] op  [10] = '{OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI, OP_SW, OP_SW, OP_SW, OP_SW, OP_SW, OP_SW};
        logic       rdy [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [3:0] st  [10] = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
        logic [7:0] sb  [10] = '{SB_F1, SB_NONE, SB_NONE, SB_IWB, SB_F0, SB_F1, SB_NONE, SB_NONE, SB_MW, SB_MW};
        logic [6:0] sl  [10] = '{SL_F, SL_DEC, SL_AE, SL_0, SL_F, SL_F, SL_DEC, SL_MA, SL_0, SL_0};
        logic [3:0] ms  [10] = '{MS_0, MS_0, MS_0, MS_DONE, MS_0, MS_0, MS_0, MS_0, MS_0, MS_DONE};
        for (int i = 0; i < 10; i++) begin
            opcode = op[i];
            mem_ready = rdy[i];
            @(negedge clk);
            checks++; if (state !== st[i]) begin errors++; $display("[TB] FAIL addisw_state[%0d] got=%0d exp=%0d", i, state, st[i]); end
            checks++; if (strb !== sb[i]) begin errors++; $display("[TB] FAIL addisw_strb[%0d] got=%b exp=%b", i, strb, sb[i]); end
            checks++; if (sel !== sl[i]) begin errors++; $display("[TB] FAIL addisw_sel[%0d] got=%b exp=%b", i, sel, sl[i]); end
            checks++; if (misc !== ms[i]) begin errors++; $display("[TB] FAIL addisw_misc[%0d] got=%b exp=%b", i, misc, ms[i]); end
            @(posedge clk); #1;
        end
        checks++; if (instr_count !== 4'd6) begin errors++; $display("[TB] FAIL addisw_count got=%0d exp=6", instr_count); end
    endtask

    task automatic test_illegal();
        logic [3:0] st [2] = '{4'd0, 4'd1};
        logic [7:0] sb [2] = '{SB_F1, SB_NONE};
        logic [6:0] sl [2] = '{SL_F, SL_DEC};
        logic [3:0] ms [2] = '{MS_0, MS_ILL};
        opcode = OP_BAD; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (state !== st[i]) begin errors++; $display("[TB] FAIL ill_state[%0d] got=%0d exp=%0d", i, state, st[i]); end
            checks++; if (strb !== sb[i]) begin errors++; $display("[TB] FAIL ill_strb[%0d] got=%b exp=%b", i, strb, sb[i]); end
            checks++; if (sel !== sl[i]) begin errors++; $display("[TB] FAIL ill_sel[%0d] got=%b exp=%b", i, sel, sl[i]); end
            checks++; if (misc !== ms[i]) begin errors++; $display("[TB] FAIL ill_misc[%0d] got=%b exp=%b", i, misc, ms[i]); end
            @(posedge clk); #1;
        end
        checks++; if (state !== 4'd0) begin errors++; $display("[TB] FAIL ill_end_state got=%0d exp=0", state); end
        checks++; if (instr_count !== 4'd7) begin errors++; $display("[TB] FAIL ill_count got=%0d exp=7", instr_count); end
    endtask

    task automatic test_reset_mid_lw();
        logic [3:0] st [3] = '{4'd0, 4'd1, 4'd2};
        opcode = OP_LW; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (state !== st[i]) begin errors++; $display("[TB] FAIL midrst_state[%0d] got=%0d exp=%0d", i, state, st[i]); end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        #1;
        checks++; if (state !== 4'd3) begin errors++; $display("[TB] FAIL midrst_in_read got=%0d exp=3", state); end
        checks++; if (strb !== SB_MR) begin errors++; $display("[TB] FAIL midrst_read_strb got=%b exp=%b", strb, SB_MR); end
        reset = 1'b1;
        #1;
        checks++; if (state !== 4'd0) begin errors++; $display("[TB] FAIL midrst_state got=%0d exp=0", state); end
        checks++; if (instr_count !== 4'd0) begin errors++; $display("[TB] FAIL midrst_count got=%0d exp=0", instr_count); end
        checks++; if (strb !== SB_NONE) begin errors++; $display("[TB] FAIL midrst_strb got=%b exp=%b", strb, SB_NONE); end
        checks++; if (sel !== SL_F) begin errors++; $display("[TB] FAIL midrst_sel got=%b exp=%b", sel, SL_F); end
        mem_ready = 1'b1;
        #1;
        checks++; if (strb !== SB_NONE) begin errors++; $display("[TB] FAIL midrst_rdy_strb got=%b exp=%b", strb, SB_NONE); end
        @(posedge clk); #1;
        checks++; if (state !== 4'd0) begin errors++; $display("[TB] FAIL midrst_hold_state got=%0d exp=0", state); end
        checks++; if (instr_count !== 4'd0) begin errors++; $display("[TB] FAIL midrst_hold_count got=%0d exp=0", instr_count); end
        opcode = OP_J;
        reset = 1'b0;
    endtask

    task automatic test_jump_wrap();
        logic [3:0] st [3] = '{4'd0, 4'd1, 4'd9};
        logic [7:0] sb [3] = '{SB_F1, SB_NONE, SB_JMP};
        logic [6:0] sl [3] = '{SL_F, SL_DEC, SL_J};
        logic [3:0] ms [3] = '{MS_0, MS_0, MS_DONE};
        logic [3:0] exp_cnt = 4'd0;
        opcode = OP_J; mem_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                checks++; if (state !== st[i]) begin errors++; $display("[TB] FAIL j%0d_state[%0d] got=%0d exp=%0d", n, i, state, st[i]); end
                checks++; if (strb !== sb[i]) begin errors++; $display("[TB] FAIL j%0d_strb[%0d] got=%b exp=%b", n, i, strb, sb[i]); end
                checks++; if (sel !== sl[i]) begin errors++; $display("[TB] FAIL j%0d_sel[%0d] got=%b exp=%b", n, i, sel, sl[i]); end
                checks++; if (misc !== ms[i]) begin errors++; $display("[TB] FAIL j%0d_misc[%0d] got=%b exp=%b", n, i, misc, ms[i]); end
                @(posedge clk); #1;
            end
            exp_cnt = exp_cnt + 4'd1;
            checks++; if (instr_count !== exp_cnt) begin errors++; $display("[TB] FAIL j%0d_count got=%0d exp=%0d", n, instr_count, exp_cnt); end
        end
        checks++; if (instr_count !== 4'd0) begin errors++; $display("[TB] FAIL jwrap_count got=%0d exp=0", instr_count); end
    endtask

    initial begin
        reset = 1'b1;
        opcode = OP_R;
        mem_ready = 1'b1;
        test_reset();
        test_rtype();
        test_lw_stall();
        test_branches();
        test_addi_sw();
        test_illegal();
        test_reset_mid_lw();
        test_jump_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle 32-bit MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back steps. Drives the datapath mux selects, register and memory strobes, and the 2-bit `alu_op` consumed by the ALU control decoder. Sits between the instruction register opcode field and the datapath; stalls on a memory ready handshake and keeps a retired-instruction count.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports (clock and reset first):
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `opcode` in 6: IR[31:26]. Stable from DECODE until the next FETCH completes.
- `mem_ready` in 1: memory has completed the current read/write this cycle.
- `pc_write` out 1: unconditional PC load.
- `branch_eq` out 1: PC load if ALU zero.
- `branch_ne` out 1: PC load if ALU not zero.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `ir_write` out 1: instruction register load.
- `mem_to_reg` out 1: write-back data select; 1 = MDR, 0 = ALUOut.
- `reg_dst` out 1: destination register select; 1 = rd, 0 = rt.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 1: ALU A select; 0 = PC, 1 = reg A.
- `alu_src_b` out 2: ALU B select; 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_op` out 2: 00 = add, 01 = subtract (branch compare), 10 = R-type funct decode, 11 = addi (add).
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state` out 4: current state encoding, for debug.
- `illegal_op` out 1: unsupported opcode seen in DECODE (one-cycle pulse).
- `instr_done` out 1: last cycle of an instruction (one-cycle pulse).
- `instr_count` out CNT_W: retired-instruction counter.

## Operation
Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010.

State encoding:
- FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11.
- Codes 12–15 are unused; any of them returns to FETCH on the next edge.

Outputs are decoded from `state`, plus `opcode` and `mem_ready` where noted. Every output not listed for a state is 0.
- FETCH: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00.
  - `pc_write` = `ir_write` = `mem_ready`.
  - Stay in FETCH while `mem_ready`=0; go to DECODE when it is 1.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (branch target precompute). Next state by opcode:
  - lw/sw → MEM_ADDR
  - R-type → EXECUTE
  - beq/bne → BRANCH
  - j → JUMP
  - addi → ADDI_EXEC
  - other → FETCH, with `illegal_op`=1 and `instr_done`=1.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next: lw → MEM_READ, sw → MEM_WRITE.
- MEM_READ: `mem_read`=1, `iord`=1. Hold until `mem_ready`, then go to MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `instr_done`=1. Next: FETCH.
- MEM_WRITE: `mem_write`=1, `iord`=1. Hold until `mem_ready`; then `instr_done`=1 and go to FETCH.
- EXECUTE: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next: ALU_WB.
- ALU_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `instr_done`=1. Next: FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_source`=01, `instr_done`=1. Next: FETCH.
  - `branch_eq`=1 if `opcode` is beq; `branch_ne`=1 if `opcode` is bne.
- JUMP: `pc_write`=1, `pc_source`=10, `instr_done`=1. Next: FETCH.
- ADDI_EXEC: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=11. Next: ADDI_WB.
- ADDI_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0, `instr_done`=1. Next: FETCH.

Counter:
- `instr_count` increments by 1 on each clock edge where `instr_done`=1, including illegal opcodes.
- Wraps modulo 2^CNT_W with no flag.

## Timing
- Reset:
  - `state`=FETCH, `instr_count`=0.
  - While `reset` is high, `pc_write`, `ir_write`, `mem_read` and `mem_write` are forced to 0.
  - All other outputs take their FETCH values: `alu_src_b`=01; every other output 0.
- Reset asserted mid-instruction aborts it immediately. No strobe survives into the reset cycle, and the count is not incremented.
- Cycles per instruction with `mem_ready` held at 1:
  - lw 5; sw 4; R-type 4; addi 4; beq/bne 3; j 3; illegal 2.
- Each cycle with `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle; all outputs hold steady during the stall.
- `mem_ready` is ignored in every other state.
- `instr_done` and `illegal_op` are combinational, one cycle wide. The counter updates on the same edge that leaves the last state.

## Test plan
- Reset pulse in the middle of a lw, in MEM_READ → `state`=0, `instr_count`=0, `mem_read`=0 while reset is high; after release, FETCH resumes.
- R-type (`opcode`=000000), `mem_ready`=1 → states 0,1,6,7,0; `alu_op`=10 in EXECUTE; `reg_write`=1 and `reg_dst`=1 in ALU_WB; `instr_count` 0→1.
- lw with `mem_ready` low for 3 cycles in MEM_READ → states 0,1,2,3,3,3,3,4,0 (8 cycles); `iord`=1 throughout MEM_READ; `mem_to_reg`=1 in MEM_WB.
- beq then bne → BRANCH shows `branch_eq`=1/`branch_ne`=0, then the reverse; `alu_op`=01 and `pc_source`=01 both times; 3 cycles each.
- `opcode`=111111 → DECODE pulses `illegal_op`=1; return to FETCH; count +1; no `reg_write` or `mem_write` at any point.
- CNT_W=4, 16 consecutive j instructions → `instr_count` wraps 15→0; each j takes 3 cycles with `pc_write`=1 and `pc_source`=10 in JUMP.
